tx_serial_paridade: RTL

TX_SERIAL_PARIDADE -- requirements
Module: tx_serial_paridade

---
 rtl/tx_serial_paridade_pkg.sv | 15 +
 rtl/paridade.sv | 9 +
 rtl/tx_serial_paridade.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tx_serial_paridade_pkg.sv
// Shared definitions for the serial transmitter with even parity.
package tx_serial_paridade_pkg;

    localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/paridade.sv
// Even-parity generator: parity_out makes the total count of ones even.
module paridade (
    input  logic [7:0] data_in,
    output logic       parity_out
);

    assign parity_out = ^data_in;

endmodule

// File: rtl/tx_serial_paridade.sv
// Serial byte transmitter: start, 8 data bits LSB first, even parity, stop.
// Handshake is valid/ready; a latched copy of the byte drives the frame.
module tx_serial_paridade
    import tx_serial_paridade_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic       done_out
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             parity_w;
    logic             bit_end;

    paridade u_paridade (
        .data_in    (data_in),
        .parity_out (parity_w)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        bit_end = (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    data_d  = data_in;
                    par_d   = parity_w;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Line level is decided from the upcoming state so tx_out is a clean flop.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[idx_d];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_out    = tx_q;
    assign ready_out = (state_q == ST_IDLE);
    assign busy_out  = (state_q != ST_IDLE);
    assign done_out  = (state_q == ST_STOP) && bit_end;

endmodule
